// File: rtl/key_debounce_multi.sv
// Multi-key debouncer for active-low buttons: per-key sync, symmetric stability filter,
// press/release/long-press pulses. Define KEY_DEBOUNCE_REPEAT_EN for auto-repeat while held.
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS      = 3,
  parameter int unsigned WAIT_CYCLES   = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned CW       = $clog2(WAIT_CYCLES);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW       = $clog2(HOLD_MAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [HW-1:0] LONG_PRE = HW'(LONG_CYCLES - 2);
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } hold_state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync_q, sync_d;
  logic [NUM_KEYS-1:0] key_value_q, key_value_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  logic [NUM_KEYS-1:0] key_long_q, key_long_d;
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];
  logic [HW-1:0]       hold_q  [NUM_KEYS];
  logic [HW-1:0]       hold_d  [NUM_KEYS];
  hold_state_e         state_q [NUM_KEYS];
  hold_state_e         state_d [NUM_KEYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync_q        <= '1;
      key_value_q   <= '1;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_long_q    <= '0;
      cnt_q         <= '{default: '0};
      hold_q        <= '{default: '0};
      state_q       <= '{default: ST_IDLE};
    end else begin
      sync1_q       <= sync1_d;
      sync_q        <= sync_d;
      key_value_q   <= key_value_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    sync1_d       = key;
    sync_d        = sync1_q;
    key_value_d   = key_value_q;
    key_press_d   = '0;
    key_release_d = '0;
    key_long_d    = '0;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    state_d       = state_q;

    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (sync_q[i] == key_value_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        key_value_d[i]   = sync_q[i];
        cnt_d[i]         = '0;
        key_press_d[i]   = ~sync_q[i];
        key_release_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // An accepted release wins over a long/repeat threshold landing on the same edge.
      if (key_release_d[i]) begin
        state_d[i] = ST_IDLE;
        hold_d[i]  = '0;
      end else if (key_press_d[i]) begin
        state_d[i] = ST_HELD;
        hold_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          ST_HELD: begin
            hold_d[i] = hold_q[i] + 1'b1;
            if (hold_q[i] == LONG_PRE) begin
              state_d[i]    = ST_LONG;
              key_long_d[i] = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              hold_d[i]     = '0;
`endif
            end
          end
          ST_LONG: begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
            if (hold_q[i] == REP_LAST) begin
              key_press_d[i] = 1'b1;
              hold_d[i]      = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign key_value   = key_value_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: expected pulse cycles are queued when keys are
// driven and matched against observed pulses on the falling clock edge.
module tb_key_debounce_multi;

  localparam int NK   = 3;
  localparam int W    = 4;
  localparam int LNG  = 16;
  localparam int REP  = 8;
  localparam int LAT  = W + 2;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] key_value, key_press, key_release, key_long;

  key_debounce_multi #(
    .NUM_KEYS     (NK),
    .WAIT_CYCLES  (W),
    .LONG_CYCLES  (LNG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_ev(int c, int kind, int k);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.key  = k;
    sbq.push_back(e);
  endfunction

  // Expected pulses for key k driven low at negedge c and driven high h cycles later.
  function automatic void schedule(int k, int c, int h);
    int p, r, l;
    p = c + LAT;
    r = c + h + LAT;
    l = p + LNG - 1;
    push_ev(p, K_PRESS, k);
    if (l < r) begin
      push_ev(l, K_LONG, k);
`ifdef KEY_DEBOUNCE_REPEAT_EN
      for (int t = l + REP; t < r; t += REP) push_ev(t, K_PRESS, k);
`endif
    end
    push_ev(r, K_RELEASE, k);
  endfunction

  always @(negedge clk) begin
    logic  p;
    int    idx;
    int    j;
    string kn;
    if (mon_en) begin
      for (int k = 0; k < NK; k++) begin
        for (int t = 0; t < 3; t++) begin
          case (t)
            K_PRESS:   begin p = key_press[k];   kn = "press";   end
            K_RELEASE: begin p = key_release[k]; kn = "release"; end
            default:   begin p = key_long[k];    kn = "long";    end
          endcase
          if (p) begin
            idx = -1;
            for (int q = 0; q < sbq.size(); q++)
              if (idx < 0 && sbq[q].kind == t && sbq[q].key == k) idx = q;
            if (idx < 0) begin
              chk($sformatf("spurious_%s%0d", kn, k), 1, 0);
            end else begin
              chk($sformatf("%s%0d_cycle", kn, k), cyc, sbq[idx].cyc);
              sbq.delete(idx);
            end
          end
        end
      end
      j = 0;
      while (j < sbq.size()) begin
        if (sbq[j].cyc <= cyc) begin
          chk($sformatf("missed_kind%0d_key%0d_at%0d", sbq[j].kind, sbq[j].key, sbq[j].cyc), 0, 1);
          sbq.delete(j);
        end else begin
          j++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_hold(input logic [NK-1:0] m, input int h);
    int c;
    @(negedge clk);
    c   = cyc;
    key = key & ~m;
    for (int k = 0; k < NK; k++) if (m[k]) schedule(k, c, h);
    repeat (h) @(negedge clk);
    if (h >= LAT) chk("held_value", key_value & m, 0);
    key = key | m;
  endtask

  initial begin
    int c;
    key   = '1;
    rst_n = 1'b0;
    idle(3);
    chk("rst_value",   key_value,   3'b111);
    chk("rst_press",   key_press,   0);
    chk("rst_release", key_release, 0);
    chk("rst_long",    key_long,    0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(100);
    chk("idle_value", key_value, 3'b111);

    // 3-cycle glitch on key0 must be filtered
    @(negedge clk);
    key[0] = 1'b0;
    idle(3);
    key[0] = 1'b1;
    idle(12);
    chk("glitch_value", key_value, 3'b111);

    press_hold(3'b001, 20);
    idle(12);
    press_hold(3'b001, W);
    idle(12);

    press_hold(3'b110, 8);
    chk("k0_untouched", key_value[0], 1);
    idle(12);

    press_hold(3'b100, 40);
    idle(12);

    press_hold(3'b001, 10);
    idle(12);
    chk("after_short_hold", key_value, 3'b111);

    // key1 into LONG state, then reset while the pin stays low
    @(negedge clk);
    c      = cyc;
    key[1] = 1'b0;
    push_ev(c + LAT, K_PRESS, 1);
    push_ev(c + LAT + LNG - 1, K_LONG, 1);
    idle(25);
    chk("pre_rst_value", key_value[1], 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_value",   key_value,   3'b111);
    chk("async_rst_press",   key_press,   0);
    chk("async_rst_release", key_release, 0);
    chk("async_rst_long",    key_long,    0);
    idle(3);
    chk("in_rst_value", key_value, 3'b111);
    rst_n = 1'b1;
    c = cyc;
    schedule(1, c, 30);
    idle(30);
    chk("post_rst_held", key_value[1], 0);
    key[1] = 1'b1;

    idle(60);
    chk("final_value", key_value, 3'b111);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-key debouncer and key-event generator for active-low push-buttons. It replaces the three-key, press-only debouncer with independent per-key filtering of both the press and release edges. It produces single-cycle press, release and long-press events, with optional auto-repeat. It sits between the board key pins and the control FSMs; every consumer samples its outputs in the `clk` domain.

## Interface
- `NUM_KEYS`, default 3: number of independent keys; must be 1 to 16.
- `WAIT_CYCLES`, default 1_000_000: number of consecutive stable cycles a new level must hold before it is accepted; must be at least 2.
- `LONG_CYCLES`, default 50_000_000: number of hold cycles, counted from the accepted press, before `key_long` fires; must be greater than `WAIT_CYCLES`.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period. It is used only when `KEY_DEBOUNCE_REPEAT_EN` is defined; must be at least 2.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key`, input, `NUM_KEYS`: raw key pins, active-low (0 = pressed). Asynchronous to `clk`.
- `key_value`, output, `NUM_KEYS`: debounced level, active-low. Reset value is all ones.
- `key_press`, output, `NUM_KEYS`: one-cycle high pulse for each accepted press and each auto-repeat. Reset value is 0.
- `key_release`, output, `NUM_KEYS`: one-cycle high pulse for each accepted release. Reset value is 0.
- `key_long`, output, `NUM_KEYS`: one-cycle high pulse, fired once per press when the hold time reaches `LONG_CYCLES`. Reset value is 0.

## Operation
- Each key has a 2-flop synchronizer. Both flops reset to 1. The second flop is called `sync`.
- Each key has a stability counter of width `$clog2(WAIT_CYCLES)`.
  - While `sync` equals `key_value`, the counter is held at 0.
  - While `sync` differs from `key_value`, the counter increments.
  - On the edge where the counter equals `WAIT_CYCLES-1` and `sync` still differs, `key_value` takes the value of `sync` and the counter clears.
- A glitch shorter than `WAIT_CYCLES` cycles clears the counter and leaves `key_value` unchanged. Press and release are filtered symmetrically.
- Event pulses:
  - `key_press` is high for the one cycle after `key_value` goes from 1 to 0.
  - `key_release` is high for the one cycle after `key_value` goes from 0 to 1.
  - Both pulses are registered; they assert on the same edge that updates `key_value`.
- Each key has a hold counter of width `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`.
  - It clears on a press and counts while `key_value` is 0.
  - On the edge where it reaches `LONG_CYCLES-1`, `key_long` pulses.
  - After that, the counter saturates; with repeat enabled it runs the repeat phase instead.
  - A release at any point clears the hold counter and returns the key to IDLE. No `key_long` fires for a release before the threshold.
- Per-key hold state machine:
  - IDLE → HELD on an accepted press.
  - HELD → LONG on reaching the long threshold.
  - HELD or LONG → IDLE on an accepted release.
- Keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- When `rst_n` is asserted at any point, all outputs, counters and state machines take their reset values immediately. No event pulse is generated on or after reset release while the pins are idle high.

## Timing
- Press latency: if the raw pin goes low and stays low before clock edge 0, `key_value` goes low and `key_press` pulses after edge `WAIT_CYCLES+1`. This is 2 cycles of synchronizer plus the stability filter. Release latency is identical.
- `key_long` fires exactly `LONG_CYCLES-1` cycles after the `key_press` pulse cycle.
- Pulses are exactly one cycle wide and never back-to-back on the same key from a single event.
- All outputs are registered, with no combinational path from `key` to any output.

## Configuration
- `KEY_DEBOUNCE_REPEAT_EN` defined:
  - In LONG state, `key_press` also pulses every `REPEAT_CYCLES` cycles while the key is held.
  - The first repeat comes `REPEAT_CYCLES` cycles after the `key_long` pulse.
  - The hold counter reloads to 0 on each repeat.
- `KEY_DEBOUNCE_REPEAT_EN` undefined:
  - No repeat logic is built and `REPEAT_CYCLES` is ignored.
  - LONG state holds silently until release.

## Test plan
All scenarios use `NUM_KEYS=3`, `WAIT_CYCLES=4`, `LONG_CYCLES=16`, `REPEAT_CYCLES=8`.

- Reset, then pins held at 3'b111 for 100 cycles → `key_value` stays 3'b111 and no pulses fire.
- `key[0]` low for 3 cycles, then high → no change. `key[0]` low and held → `key_value[0]`=0 and `key_press[0]` pulses once, 5 cycles after the first low sample. On release, `key_release[0]` pulses 5 cycles later.
- `key[1]` and `key[2]` pressed on the same cycle → both `key_press` bits pulse in the same cycle. `key[0]` is unaffected.
- `key[2]` held for 40 cycles → `key_long[2]` pulses once, 15 cycles after `key_press[2]`. With `KEY_DEBOUNCE_REPEAT_EN`, `key_press[2]` repeats 8, 16, … cycles after `key_long`; without it, no further pulses fire.
- Press `key[0]`, release at hold count 10 → `key_release[0]` pulses and `key_long[0]` never pulses.
- Assert `rst_n` while `key[1]` is held in LONG state → all outputs take their reset values immediately. After release of `rst_n` with the pin still low, a fresh press is accepted after the full latency.
